// File: rtl/exit_status_reporter.sv
// exit_status_reporter
// Captures the x_heep_system exit value on each rising edge of the exit-valid
// strobe. It then prints the line "EXIT XXXXXXXX\r\n" (8 uppercase hex digits)
// on a dedicated 8N1 debug UART pin. It also drives pass/fail LEDs, so a board
// run can report its result without JTAG.
//
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   exit_valid_i exit strobe (level); a rising edge seen in IDLE triggers a line
//   exit_value_i 32-bit exit value, sampled only on the trigger cycle
//   uart_tx_o    registered 8N1 serial output, idle high
//   busy_o       registered, high while a line is being transmitted
//   pass_led_o   high once the last captured value was zero
//   fail_led_o   high once the last captured value was nonzero
module exit_status_reporter #(
  parameter int CLKS_PER_BIT = 130
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        pass_led_o,
  output logic        fail_led_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_CHAR = 4'd14;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        char_idx_q, char_idx_d;
  logic [31:0]       value_q, value_d;
  logic              valid_q, valid_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;

  logic [7:0]        char_byte;
  logic [3:0]        nibble;
  logic              is_digit;
  logic              baud_last;

  // Character currently being sent. It is chosen from the index and the held
  // value. Indices 5..12 are the hex digits, most significant nibble first.
  always_comb begin
    nibble    = 4'h0;
    char_byte = 8'h0A;
    is_digit  = (char_idx_q >= 4'd5) && (char_idx_q <= 4'd12);
    case (char_idx_q)
      4'd0:    char_byte = 8'h45;
      4'd1:    char_byte = 8'h58;
      4'd2:    char_byte = 8'h49;
      4'd3:    char_byte = 8'h54;
      4'd4:    char_byte = 8'h20;
      4'd13:   char_byte = 8'h0D;
      default: char_byte = 8'h0A;
    endcase
    case (char_idx_q)
      4'd5:    nibble = value_q[31:28];
      4'd6:    nibble = value_q[27:24];
      4'd7:    nibble = value_q[23:20];
      4'd8:    nibble = value_q[19:16];
      4'd9:    nibble = value_q[15:12];
      4'd10:   nibble = value_q[11:8];
      4'd11:   nibble = value_q[7:4];
      4'd12:   nibble = value_q[3:0];
      default: nibble = 4'h0;
    endcase
    if (is_digit) begin
      char_byte = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                   : (8'h37 + {4'h0, nibble});
    end
  end

  assign baud_last = (baud_cnt_q == BAUD_LAST);

  // Next-state logic for the transmitter. tx_d is the value the pin takes
  // after this edge. It is computed here so the pin itself comes straight
  // from a flop. valid_q follows the strobe every cycle, including while
  // busy, so a line only starts on a fresh rising edge.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    char_idx_d = char_idx_q;
    value_d    = value_q;
    valid_d    = exit_valid_i;
    tx_d       = tx_q;
    busy_d     = busy_q;
    pass_d     = pass_q;
    fail_d     = fail_q;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (exit_valid_i && !valid_q) begin
          state_d    = START;
          value_d    = exit_value_i;
          pass_d     = (exit_value_i == 32'h0);
          fail_d     = (exit_value_i != 32'h0);
          char_idx_d = 4'd0;
          baud_cnt_d = '0;
          bit_cnt_d  = 3'd0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_cnt_d  = 3'd0;
          state_d    = DATA;
          tx_d       = char_byte[0];
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = char_byte[bit_cnt_q + 3'd1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (char_idx_q < LAST_CHAR) begin
            char_idx_d = char_idx_q + 4'd1;
            state_d    = START;
            tx_d       = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register. Reset has priority over a trigger on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      char_idx_q <= 4'd0;
      value_q    <= 32'h0;
      valid_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      char_idx_q <= char_idx_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  assign uart_tx_o  = tx_q;
  assign busy_o     = busy_q;
  assign pass_led_o = pass_q;
  assign fail_led_o = fail_q;

endmodule
